// File: rtl/program_sequencer_pkg.sv
// ============================================================================
// program_sequencer_pkg : shared state type and default sizing constants
// Rev 1.0
// ============================================================================
`default_nettype none

package program_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        LOG   = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam int DEF_NUM_PROGS  = 3;
    localparam int DEF_MAX_CYCLES = 50000;

endpackage

`default_nettype wire

// File: rtl/program_sequencer_run_counter.sv
// ============================================================================
// run_counter : clearable, enabled up-counter saturating at a limit
// Rev 1.0
// ============================================================================
`default_nettype none

module run_counter #(
    parameter int CNT_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [CNT_BITS-1:0] limit,
    output logic [CNT_BITS-1:0] count,
    output logic                terminal
);

    logic [CNT_BITS-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != limit)) begin
            r_count <= r_count + CNT_BITS'(1);
        end
    end

    assign count    = r_count;
    assign terminal = (r_count == limit);

endmodule

`default_nettype wire

// File: rtl/program_sequencer.sv
// ============================================================================
// program_sequencer : runs each stored program on the core, logs cycle counts
// and timeouts, and reports completion to the host with a level handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int NUM_PROGS    = DEF_NUM_PROGS,
    parameter int SEL_BITS     = 2,
    parameter int CNT_BITS     = 16,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int START_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 host_req,
    output logic                 host_ack,
    output logic                 busy,
    output logic                 core_start,
    input  logic                 core_ack,
    output logic [SEL_BITS-1:0]  prog_sel,
    output logic [CNT_BITS-1:0]  cyc_count,
    input  logic [SEL_BITS-1:0]  rd_sel,
    output logic [CNT_BITS-1:0]  rd_count,
    output logic [NUM_PROGS-1:0] timeout_mask
);

    localparam logic [CNT_BITS-1:0] c_max_count   = CNT_BITS'(MAX_CYCLES);
    localparam logic [CNT_BITS-1:0] c_run_limit   = CNT_BITS'(MAX_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] c_start_limit = CNT_BITS'(START_CYCLES - 1);
    localparam logic [SEL_BITS-1:0] c_last_prog   = SEL_BITS'(NUM_PROGS - 1);

    seq_state_t            r_state, w_state_next;
    logic [SEL_BITS-1:0]   r_prog_sel;
    logic [CNT_BITS-1:0]   r_log [NUM_PROGS];
    logic [NUM_PROGS-1:0]  r_mask;
    logic [CNT_BITS-1:0]   w_start_cnt_unused;
    logic                  w_start_done;
    logic                  w_run_limit;
    logic                  w_log_wr, w_log_to, w_log_clr, w_sel_clr, w_sel_inc;

    run_counter #(.CNT_BITS(CNT_BITS)) u_start_cnt (
        .clock    (clock),
        .reset    (reset),
        .clear    (r_state != START),
        .enable   (r_state == START),
        .limit    (c_start_limit),
        .count    (w_start_cnt_unused),
        .terminal (w_start_done)
    );

    // Cleared on the last START cycle so the first RUN cycle reads zero.
    run_counter #(.CNT_BITS(CNT_BITS)) u_run_cnt (
        .clock    (clock),
        .reset    (reset),
        .clear    ((r_state == START) && w_start_done),
        .enable   ((r_state == RUN) && !core_ack && !w_run_limit),
        .limit    (c_run_limit),
        .count    (cyc_count),
        .terminal (w_run_limit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_log_wr     = 1'b0;
        w_log_to     = 1'b0;
        w_log_clr    = 1'b0;
        w_sel_clr    = 1'b0;
        w_sel_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (host_req) begin
                    w_log_clr    = 1'b1;
                    w_sel_clr    = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_start_done) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // A same-cycle ack beats the limit, so no timeout is logged.
                if (core_ack) begin
                    w_log_wr     = 1'b1;
                    w_state_next = LOG;
                end else if (w_run_limit) begin
                    w_log_wr     = 1'b1;
                    w_log_to     = 1'b1;
                    w_state_next = LOG;
                end
            end
            LOG: begin
                if (r_prog_sel == c_last_prog) begin
                    w_state_next = DONE;
                end else begin
                    w_sel_inc    = 1'b1;
                    w_state_next = START;
                end
            end
            DONE: begin
                if (!host_req) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || w_sel_clr) begin
            r_prog_sel <= '0;
        end else if (w_sel_inc) begin
            r_prog_sel <= r_prog_sel + SEL_BITS'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_log_clr) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
                r_log[i] <= '0;
            end
            r_mask <= '0;
        end else if (w_log_wr) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
                if (r_prog_sel == SEL_BITS'(i)) begin
                    r_log[i]  <= w_log_to ? c_max_count : cyc_count;
                    r_mask[i] <= w_log_to;
                end
            end
        end
    end

    always_comb begin
        rd_count = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (rd_sel == SEL_BITS'(i)) begin
                rd_count = r_log[i];
            end
        end
    end

    assign core_start   = (r_state != RUN);
    assign host_ack     = (r_state == DONE);
    assign busy         = (r_state == START) || (r_state == RUN) || (r_state == LOG);
    assign prog_sel     = r_prog_sel;
    assign timeout_mask = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// ============================================================================
// tb_program_sequencer : directed bench with a reference model and core model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_program_sequencer;

    localparam int NP   = 3;
    localparam int SB   = 2;
    localparam int CB   = 16;
    localparam int MAXC = 100;
    localparam int SC   = 2;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          host_req = 1'b0;
    logic          core_ack = 1'b0;
    logic [SB-1:0] rd_sel   = '0;
    logic          host_ack, busy, core_start;
    logic [SB-1:0] prog_sel;
    logic [CB-1:0] cyc_count, rd_count;
    logic [NP-1:0] timeout_mask;

    program_sequencer #(
        .NUM_PROGS(NP), .SEL_BITS(SB), .CNT_BITS(CB),
        .MAX_CYCLES(MAXC), .START_CYCLES(SC)
    ) dut (
        .clock(clock), .reset(reset), .host_req(host_req), .host_ack(host_ack),
        .busy(busy), .core_start(core_start), .core_ack(core_ack),
        .prog_sel(prog_sel), .cyc_count(cyc_count), .rd_sel(rd_sel),
        .rd_count(rd_count), .timeout_mask(timeout_mask)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    // Reference model: phase of the sequence plus plain integer bookkeeping.
    localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_LOG = 3, M_DONE = 4;
    int m_mode = M_IDLE;
    int m_prog = 0, m_hold = 0, m_cyc = 0, m_mask = 0;
    int m_log [NP] = '{0, 0, 0};

    task automatic model_step();
        if (reset) begin
            m_mode = M_IDLE; m_prog = 0; m_hold = 0; m_cyc = 0; m_mask = 0;
            for (int i = 0; i < NP; i++) m_log[i] = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (host_req) begin
                    for (int i = 0; i < NP; i++) m_log[i] = 0;
                    m_mask = 0; m_prog = 0; m_hold = 0; m_mode = M_START;
                end
                M_START: if (m_hold == SC - 1) begin
                    m_cyc = 0; m_mode = M_RUN;
                end else m_hold++;
                M_RUN: if (core_ack) begin
                    m_log[m_prog] = m_cyc; m_mode = M_LOG;
                end else if (m_cyc == MAXC - 1) begin
                    m_log[m_prog] = MAXC; m_mask |= (1 << m_prog); m_mode = M_LOG;
                end else m_cyc++;
                M_LOG: if (m_prog == NP - 1) m_mode = M_DONE;
                else begin
                    m_prog++; m_hold = 0; m_mode = M_START;
                end
                default: if (!host_req) m_mode = M_IDLE;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
        #2;
        check("core_start", core_start, int'(m_mode != M_RUN));
        check("host_ack", host_ack, int'(m_mode == M_DONE));
        check("busy", busy, int'(m_mode == M_START || m_mode == M_RUN || m_mode == M_LOG));
        check("prog_sel", prog_sel, m_prog);
        check("cyc_count", cyc_count, m_cyc);
        check("timeout_mask", timeout_mask, m_mask);
        check("rd_count", rd_count, (rd_sel < NP) ? m_log[rd_sel] : 0);
    end

    // Core model: acks after target[prog] RUN cycles; optionally acks during start.
    int target [NP] = '{1000, 1000, 1000};
    bit ack_in_start = 1'b0;
    int runs = 0;

    initial forever begin
        @(negedge clock);
        if (core_start) begin
            runs     = 0;
            core_ack = ack_in_start;
        end else begin
            core_ack = (runs == target[prog_sel]);
            runs++;
        end
    end

    task automatic run_seq(input int t0, input int t1, input int t2,
                           input bit early, input bit drop_in_run);
        int lat;
        target[0] = t0; target[1] = t1; target[2] = t2;
        ack_in_start = early;
        host_req = 1'b1;
        lat = 0;
        for (int i = 0; i < 20 && (lat == 0 || core_start); i++) begin
            @(negedge clock);
            lat++;
        end
        check("req_to_run_latency", lat, SC + 1);
        if (drop_in_run) host_req = 1'b0;
        for (int i = 0; i < 3000 && !host_ack; i++) @(negedge clock);
        if (!host_ack) begin
            n_checks++;
            $display("FAIL wait_host_ack: got 0 expected 1");
        end
    endtask

    task automatic check_log(input int e0, input int e1, input int e2, input int emask);
        rd_sel = 2'd0; #1 check("log0", rd_count, e0);
        rd_sel = 2'd1; #1 check("log1", rd_count, e1);
        rd_sel = 2'd2; #1 check("log2", rd_count, e2);
        rd_sel = 2'd3; #1 check("log_oob", rd_count, 0);
        rd_sel = 2'd0;
        check("mask", timeout_mask, emask);
    endtask

    task automatic finish_seq();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("ack_held", host_ack, 1);
            check("no_rerun", busy, 0);
        end
        host_req = 1'b0;
        @(negedge clock);
        check("ack_dropped", host_ack, 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_core_start", core_start, 1);
        check("rst_host_ack", host_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_cyc", cyc_count, 0);
        check_log(0, 0, 0, 0);

        // Reset while program 1 is mid-run
        target[0] = 5; target[1] = 1000; target[2] = 1000;
        ack_in_start = 1'b0;
        host_req = 1'b1;
        for (int i = 0; i < 500 && !(prog_sel == 2'd1 && cyc_count == 16'd40); i++)
            @(negedge clock);
        check("reached_mid_run", int'(prog_sel == 2'd1 && cyc_count == 16'd40), 1);
        reset = 1'b1; host_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_core_start", core_start, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_prog_sel", prog_sel, 0);
        check_log(0, 0, 0, 0);
        @(negedge clock);

        run_seq(10, 20, 30, 1'b0, 1'b0);
        check_log(10, 20, 30, 0);
        finish_seq();

        run_seq(12, -1, 25, 1'b0, 1'b0);
        check_log(12, MAXC, 25, 3'b010);
        finish_seq();

        run_seq(MAXC - 1, 3, 7, 1'b0, 1'b0);
        check_log(MAXC - 1, 3, 7, 0);
        finish_seq();

        run_seq(0, 0, 0, 1'b1, 1'b0);
        check_log(0, 0, 0, 0);
        finish_seq();
        ack_in_start = 1'b0;

        run_seq(10, 20, 30, 1'b0, 1'b1);
        check_log(10, 20, 30, 0);
        @(negedge clock);
        check("ack_one_cycle", host_ack, 0);
        check("idle_after_drop", busy, 0);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
